logic_exec_pipe: RTL and testbench

- Two-stage pipelined execution stage for the processor's 32-bit logical operations: AND, OR, XOR, NAND, NOR, XNOR and NOT.
- Sits between issue/decode and writeback:
  - stage 1 registers the operands and opcode;
  - stage 2 registers the selected result plus status flags.
- Valid/ready handshakes on both sides, so writeback can stall the pipe without losing or duplicating operations.

---
 rtl/logic_exec_pipe.sv | 147 ++++++++++++++
 tb/tb_logic_exec_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_exec_pipe.sv
// Two-stage pipelined 32-bit logical execution unit (AND/OR/XOR/NAND/NOR/XNOR/NOT)
// with valid/ready handshakes on both sides and zero/parity/illegal status flags.
module logic_exec_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic             illegal,
    output logic [TAG_W-1:0] tag_out
);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_ILL  = 3'd7
    } op_e;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    op_e              s1_op_q, s1_op_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;
    logic             illegal_q, illegal_d;
    logic [TAG_W-1:0] tag_out_q, tag_out_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             in_xfer;
    logic [WIDTH-1:0] f_res;

    // Handshake depends only on state and out_ready, never on in_valid.
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_adv;
        in_ready = !s1_valid_q || s2_adv;
        in_xfer  = in_valid && in_ready;
    end

    always_comb begin
        f_res = '0;
        case (s1_op_q)
            OP_AND:  f_res = s1_a_q & s1_b_q;
            OP_OR:   f_res = s1_a_q | s1_b_q;
            OP_XOR:  f_res = s1_a_q ^ s1_b_q;
            OP_NAND: f_res = ~(s1_a_q & s1_b_q);
            OP_NOR:  f_res = ~(s1_a_q | s1_b_q);
            OP_XNOR: f_res = ~(s1_a_q ^ s1_b_q);
            OP_NOT:  f_res = ~s1_a_q;
            OP_ILL:  f_res = '0;
            default: f_res = '0;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_tag_d   = s1_tag_q;
        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_a_d     = a;
            s1_b_d     = b;
            s1_op_d    = op_e'(op);
            s1_tag_d   = tag_in;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        zero_d     = zero_q;
        parity_d   = parity_q;
        illegal_d  = illegal_q;
        tag_out_d  = tag_out_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            result_d   = f_res;
            zero_d     = (f_res == '0);
            parity_d   = ^f_res;
            illegal_d  = (s1_op_q == OP_ILL);
            tag_out_d  = s1_tag_q;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= OP_AND;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            parity_q   <= 1'b0;
            illegal_q  <= 1'b0;
            tag_out_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            parity_q   <= parity_d;
            illegal_q  <= illegal_d;
            tag_out_q  <= tag_out_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign parity    = parity_q;
    assign illegal   = illegal_q;
    assign tag_out   = tag_out_q;

endmodule

// File: tb/tb_logic_exec_pipe.sv
// Self-checking bench for logic_exec_pipe: directed scenarios plus a randomized
// stream scored against an in-order queue of expected results.
module tb_logic_exec_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [3:0]  tag_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        parity;
    logic        illegal;
    logic [3:0]  tag_out;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        p;
        logic        il;
        logic [3:0]  t;
    } exp_t;

    exp_t q[$];

    logic_exec_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .tag_in(tag_in), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .parity(parity),
        .illegal(illegal), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_f(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x & y);
            3'd4: return ~(x | y);
            3'd5: return ~(x ^ y);
            3'd6: return ~x;
            default: return 32'd0;
        endcase
    endfunction

    function automatic exp_t mk_exp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [3:0] t);
        exp_t e;
        e.r  = ref_f(o, x, y);
        e.z  = (e.r == 32'd0);
        e.p  = (($countones(e.r) % 2) == 1);
        e.il = (o == 3'd7);
        e.t  = t;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] t, input logic ordy);
        in_valid = v; op = o; a = x; b = y; tag_in = t; out_ready = ordy;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0, 1'b0);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if ({result, zero, parity, illegal, tag_out} !== 39'd0)
            begin n_fail++; $display("FAIL reset_outputs: got %h/%b%b%b/%h expected all zero", result, zero, parity, illegal, tag_out); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [2:0] o;
        for (int k = 0; k < 2; k++) begin
            o = 3'(k);
            drive(1'b1, o, 32'h3333_3333, 32'hCCCC_CCCC, 4'(k + 1), 1'b1);
            @(negedge clk);
            drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0, 1'b1);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early: got %b expected 0", out_valid); end
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
            n_checks++;
            if (result !== (k == 0 ? 32'h0000_0000 : 32'hFFFF_FFFF) || zero !== (k == 0) || parity !== 1'b0 || tag_out !== 4'(k + 1))
                begin n_fail++; $display("FAIL basic_op%0d: got %h z%b p%b t%h", k, result, zero, parity, tag_out); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        for (int k = 0; k < 9; k++) begin
            if (k >= 2) begin
                e = mk_exp(3'(k - 2), 32'hFFFF_FFFF, 32'hF0F0_F0F0, 4'(k - 2));
                n_checks++;
                if (out_valid !== 1'b1 || result !== e.r || zero !== e.z || parity !== e.p || tag_out !== e.t)
                    begin n_fail++; $display("FAIL b2b_%0d: got v%b %h z%b p%b t%h expected %h z%b p%b t%h",
                                             k - 2, out_valid, result, zero, parity, tag_out, e.r, e.z, e.p, e.t); end
            end
            if (k < 7) drive(1'b1, 3'(k), 32'hFFFF_FFFF, 32'hF0F0_F0F0, 4'(k), 1'b1);
            else       drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0, 1'b1);
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_%0d: got %b expected 1", k, in_ready); end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal;
        drive(1'b1, 3'd7, 32'h5555_5555, 32'hAAAA_AAAA, 4'd3, 1'b1);
        @(negedge clk);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0, 1'b1);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'd0 || illegal !== 1'b1 || zero !== 1'b1 || parity !== 1'b0 || tag_out !== 4'd3)
            begin n_fail++; $display("FAIL illegal_op: got v%b %h il%b z%b p%b t%h expected 1 00000000 il1 z1 p0 t3",
                                     out_valid, result, illegal, zero, parity, tag_out); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        exp_t        ea;
        exp_t        eb;
        exp_t        ec;
        logic [31:0] held_r;
        ea = mk_exp(3'd2, 32'h1234_5678, 32'h0F0F_0F0F, 4'd1);
        eb = mk_exp(3'd6, 32'h00FF_00FF, 32'h0, 4'd2);
        ec = mk_exp(3'd4, 32'h8000_0001, 32'h0000_0010, 4'd3);
        drive(1'b1, 3'd2, 32'h1234_5678, 32'h0F0F_0F0F, 4'd1, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'd6, 32'h00FF_00FF, 32'h0, 4'd2, 1'b0);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_second_accept: got %b expected 1", in_ready); end
        @(negedge clk);
        drive(1'b1, 3'd4, 32'h8000_0001, 32'h0000_0010, 4'd3, 1'b0);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready: got %b expected 0", in_ready); end
        held_r = result;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || result !== held_r || result !== ea.r || tag_out !== 4'd1 || zero !== ea.z || parity !== ea.p)
            begin n_fail++; $display("FAIL bp_stable: got v%b %h t%h expected %h t1", out_valid, result, tag_out, ea.r); end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || result !== eb.r || tag_out !== 4'd2 || zero !== eb.z || parity !== eb.p)
            begin n_fail++; $display("FAIL bp_deliver_2: got v%b %h t%h expected %h t2", out_valid, result, tag_out, eb.r); end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || result !== ec.r || tag_out !== 4'd3 || zero !== ec.z || parity !== ec.p)
            begin n_fail++; $display("FAIL bp_deliver_3: got v%b %h t%h expected %h t3", out_valid, result, tag_out, ec.r); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_simultaneous;
        drive(1'b1, 3'd1, 32'h1, 32'h2, 4'd7, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'd1, 32'h4, 32'h8, 4'd8, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'd1, 32'h10, 32'h20, 4'd9, 1'b1);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || tag_out !== 4'd7)
            begin n_fail++; $display("FAIL sim_full: got rdy%b v%b t%h expected rdy1 v1 t7", in_ready, out_valid, tag_out); end
        @(negedge clk);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || tag_out !== 4'd8 || result !== 32'h0000_000C)
            begin n_fail++; $display("FAIL sim_shift: got v%b %h t%h expected 0000000c t8", out_valid, result, tag_out); end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || tag_out !== 4'd9 || result !== 32'h0000_0030)
            begin n_fail++; $display("FAIL sim_accept: got v%b %h t%h expected 00000030 t9", out_valid, result, tag_out); end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight;
        drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h1, 4'd1, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'd1, 32'h2, 32'h1, 4'd2, 1'b0);
        @(negedge clk);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0 || tag_out !== 4'd0)
            begin n_fail++; $display("FAIL midreset: got v%b rdy%b %h t%h expected v0 rdy1 0 t0", out_valid, in_ready, result, tag_out); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 3'd5, 32'h0, 32'hFF00_FF00, 4'd4, 1'b1);
        @(negedge clk);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0, 1'b1);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'h00FF_00FF || tag_out !== 4'd4 || zero !== 1'b0 || parity !== 1'b0)
            begin n_fail++; $display("FAIL post_reset_op: got v%b %h t%h expected 00ff00ff t4", out_valid, result, tag_out); end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  o;
        exp_t        e;
        for (int c = 0; c < 420; c++) begin
            if (c >= 400) begin
                drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0, 1'b1);
            end else begin
                o = 3'($urandom_range(0, 7));
                x = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                y = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                drive($urandom_range(0, 3) != 0, o, x, y, 4'($urandom), $urandom_range(0, 3) != 0);
            end
            #1;
            n_checks++;
            if (in_ready !== ((q.size() < 2) || out_ready))
                begin n_fail++; $display("FAIL rnd_in_ready_%0d: got %b expected %b", c, in_ready, (q.size() < 2) || out_ready); end
            if (q.size() == 0) begin
                n_checks++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_spurious_%0d: got out_valid %b expected 0", c, out_valid); end
            end else if (out_valid === 1'b1) begin
                e = q[0];
                n_checks++;
                if (result !== e.r || zero !== e.z || parity !== e.p || illegal !== e.il || tag_out !== e.t)
                    begin n_fail++; $display("FAIL rnd_data_%0d: got %h z%b p%b il%b t%h expected %h z%b p%b il%b t%h",
                                             c, result, zero, parity, illegal, tag_out, e.r, e.z, e.p, e.il, e.t); end
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(mk_exp(op, a, b, tag_in));
            @(negedge clk);
        end
        n_checks++;
        if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got %0d ops left expected 0", q.size()); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_illegal;
        test_backpressure;
        test_simultaneous;
        test_reset_midflight;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
